// File: rtl/bus_pin_driver.sv
// rtl/bus_pin_driver.sv - sequences a latched word onto bus pins with setup/strobe/hold/turnaround timing
//
// Purpose: drives a parallel word onto external pins in four timed phases
//   (SETUP, STROBE, HOLD, TURN), each measured in `ena` ticks. Owns the
//   output enable so the bus is released during turnaround and idle.
//
// Optional feature macro: BUS_PIN_DRIVER_READBACK_EN
//   defined   - `din` is compared with the latched word on the tick that ends
//               STROBE; a mismatch sets the sticky `err` flag.
//   undefined - `din` is ignored and `err` is tied low.
//
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   ena       in   timing tick
//   req       in   transfer request (accepted only in IDLE, any cycle)
//   data      in   word to drive, captured on acceptance
//   din       in   filtered pin readback
//   ack       out  one-cycle pulse after acceptance
//   busy      out  transfer in progress
//   dout      out  pin data (all ones when not driving)
//   oe_n      out  active-low output enable
//   strobe_n  out  active-low bus strobe
//   err       out  sticky contention flag
module bus_pin_driver #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SETUP = 2,
   parameter int unsigned PULSE = 2,
   parameter int unsigned HOLD  = 1,
   parameter int unsigned TURN  = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ena,
   input  logic             req,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] din,
   output logic             ack,
   output logic             busy,
   output logic [WIDTH-1:0] dout,
   output logic             oe_n,
   output logic             strobe_n,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_TURN   = 3'd4
   } state_t;

   localparam logic [3:0] SETUP_T = 4'(SETUP);
   localparam logic [3:0] PULSE_T = 4'(PULSE);
   localparam logic [3:0] HOLD_T  = 4'(HOLD);
   localparam logic [3:0] TURN_T  = 4'(TURN);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             accept;
   logic             strobe_end;

   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             oe_n_q, oe_n_d;
   logic             strobe_n_q, strobe_n_d;
   logic             err_q, err_d;

   // Tick count loaded when a state is entered.
   function automatic logic [3:0] state_ticks(input state_t s);
      case (s)
         S_SETUP:  state_ticks = SETUP_T;
         S_STROBE: state_ticks = PULSE_T;
         S_HOLD:   state_ticks = HOLD_T;
         S_TURN:   state_ticks = TURN_T;
         default:  state_ticks = 4'd0;
      endcase
   endfunction

   // Zero-length phases are skipped by choosing the first non-empty successor.
   function automatic state_t after_strobe();
      if (HOLD_T != 4'd0)      after_strobe = S_HOLD;
      else if (TURN_T != 4'd0) after_strobe = S_TURN;
      else                     after_strobe = S_IDLE;
   endfunction

   function automatic state_t after_hold();
      if (TURN_T != 4'd0) after_hold = S_TURN;
      else                after_hold = S_IDLE;
   endfunction

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         word_q     <= '1;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         dout_q     <= '1;
         oe_n_q     <= 1'b1;
         strobe_n_q <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         dout_q     <= dout_d;
         oe_n_q     <= oe_n_d;
         strobe_n_q <= strobe_n_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic. A phase ends on the ena tick where the counter is at 1;
   // the entry edge itself is not a tick.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      strobe_end = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               accept  = 1'b1;
               state_d = (SETUP_T != 4'd0) ? S_SETUP : S_STROBE;
            end
         end
         S_SETUP: begin
            if (ena) begin
               if (cnt_q <= 4'd1) state_d = S_STROBE;
               else               cnt_d   = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (ena) begin
               if (cnt_q <= 4'd1) begin
                  strobe_end = 1'b1;
                  state_d    = after_strobe();
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         S_HOLD: begin
            if (ena) begin
               if (cnt_q <= 4'd1) state_d = after_hold();
               else               cnt_d   = cnt_q - 4'd1;
            end
         end
         S_TURN: begin
            if (ena) begin
               if (cnt_q <= 4'd1) state_d = S_IDLE;
               else               cnt_d   = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) cnt_d = state_ticks(state_d);
   end

   // Output logic: outputs are decoded from the next state and registered, so
   // they change on the same edge the state does and are glitch-free.
   always_comb begin
      word_d     = accept ? data : word_q;
      ack_d      = accept;
      busy_d     = (state_d != S_IDLE);
      oe_n_d     = 1'b1;
      strobe_n_d = 1'b1;
      dout_d     = '1;
      case (state_d)
         S_SETUP, S_HOLD: begin
            oe_n_d = 1'b0;
            dout_d = word_d;
         end
         S_STROBE: begin
            oe_n_d     = 1'b0;
            strobe_n_d = 1'b0;
            dout_d     = word_d;
         end
         default: ;
      endcase
   end

`ifdef BUS_PIN_DRIVER_READBACK_EN
   always_comb begin
      err_d = err_q;
      if (accept)                           err_d = 1'b0;
      else if (strobe_end && din != word_q) err_d = 1'b1;
   end
`else
   logic din_unused;
   logic strobe_end_unused;
   assign din_unused        = ^din;
   assign strobe_end_unused = strobe_end;
   always_comb err_d = 1'b0;
`endif

   assign ack      = ack_q;
   assign busy     = busy_q;
   assign dout     = dout_q;
   assign oe_n     = oe_n_q;
   assign strobe_n = strobe_n_q;
   assign err      = err_q;

endmodule

// File: tb/tb_bus_pin_driver.sv
// tb/tb_bus_pin_driver.sv - directed self-checking bench for bus_pin_driver
module tb_bus_pin_driver;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       ena;
   logic       req, req_f;
   logic [7:0] data, data_f, din;

   logic       ack, busy, oe_n, strobe_n, err;
   logic [7:0] dout;
   logic       ack_f, busy_f, oe_n_f, strobe_n_f, err_f;
   logic [7:0] dout_f;

   int vec_cnt = 0;
   int err_cnt = 0;

`ifdef BUS_PIN_DRIVER_READBACK_EN
   localparam logic RB_ERR = 1'b1;
`else
   localparam logic RB_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   bus_pin_driver u_def (
      .clk(clk), .reset_n(reset_n), .ena(ena), .req(req), .data(data), .din(din),
      .ack(ack), .busy(busy), .dout(dout), .oe_n(oe_n), .strobe_n(strobe_n), .err(err)
   );

   bus_pin_driver #(.WIDTH(8), .SETUP(0), .PULSE(1), .HOLD(0), .TURN(0)) u_fast (
      .clk(clk), .reset_n(reset_n), .ena(ena), .req(req_f), .data(data_f), .din(din),
      .ack(ack_f), .busy(busy_f), .dout(dout_f), .oe_n(oe_n_f), .strobe_n(strobe_n_f), .err(err_f)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ena = 1'b1; req = 1'b0; req_f = 1'b0;
      data = 8'h00; data_f = 8'h00; din = 8'h00;
      step(); step();
      vec_cnt++;
      if ({ack, busy, oe_n, strobe_n, err, dout} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF}) begin
         err_cnt++;
         $display("FAIL reset_hold got ack=%b busy=%b oe_n=%b strobe_n=%b err=%b dout=%h",
                  ack, busy, oe_n, strobe_n, err, dout);
      end
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         vec_cnt++;
         if ({ack, busy, oe_n, strobe_n, err, dout} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF}) begin
            err_cnt++;
            $display("FAIL reset_idle c=%0d got ack=%b busy=%b oe_n=%b strobe_n=%b dout=%h",
                     c, ack, busy, oe_n, strobe_n, dout);
         end
      end
      vec_cnt++;
      if ({ack_f, busy_f, oe_n_f, strobe_n_f, dout_f} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'hFF}) begin
         err_cnt++;
         $display("FAIL reset_fast got ack=%b busy=%b oe_n=%b strobe_n=%b dout=%h",
                  ack_f, busy_f, oe_n_f, strobe_n_f, dout_f);
      end
   endtask

   // Defaults: oe_n low cycles 1-5, strobe low 3-4, busy 1-6, ack cycle 1.
   task automatic test_basic();
      logic [11:0] exp_v;
      ena = 1'b1; data = 8'hA5; req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         req = 1'b0;
         exp_v = {(c == 1) ? 1'b1 : 1'b0, (c <= 6) ? 1'b1 : 1'b0, (c <= 5) ? 1'b0 : 1'b1,
                  (c == 3 || c == 4) ? 1'b0 : 1'b1, (c <= 5) ? 8'hA5 : 8'hFF};
         vec_cnt++;
         if ({ack, busy, oe_n, strobe_n, dout} !== exp_v) begin
            err_cnt++;
            $display("FAIL basic c=%0d got %h want %h", c, {ack, busy, oe_n, strobe_n, dout}, exp_v);
         end
      end
   endtask

   // ena every 4th cycle: SETUP 1-8, STROBE 9-16, HOLD 17-20, TURN 21-24.
   task automatic test_ena_slow();
      logic [11:0] exp_v;
      step();
      ena = 1'b1; data = 8'hA5; req = 1'b1;
      for (int c = 1; c <= 28; c++) begin
         step();
         req = 1'b0;
         ena = (c % 4 == 0);
         exp_v = {(c == 1) ? 1'b1 : 1'b0, (c <= 24) ? 1'b1 : 1'b0, (c <= 20) ? 1'b0 : 1'b1,
                  (c >= 9 && c <= 16) ? 1'b0 : 1'b1, (c <= 20) ? 8'hA5 : 8'hFF};
         vec_cnt++;
         if ({ack, busy, oe_n, strobe_n, dout} !== exp_v) begin
            err_cnt++;
            $display("FAIL ena_slow c=%0d got %h want %h", c, {ack, busy, oe_n, strobe_n, dout}, exp_v);
         end
      end
      ena = 1'b1;
   endtask

   // req held for cycles 0-5 with data changing at cycle 2: one ack, dout stays C3.
   task automatic test_req_held();
      int acks;
      acks = 0;
      ena = 1'b1; data = 8'hC3; req = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         req = (c <= 5);
         if (c == 2) data = 8'h11;
         if (ack) acks++;
         vec_cnt++;
         if (dout !== ((c <= 5) ? 8'hC3 : 8'hFF)) begin
            err_cnt++;
            $display("FAIL req_held_dout c=%0d got %h want %h", c, dout, (c <= 5) ? 8'hC3 : 8'hFF);
         end
      end
      vec_cnt++;
      if (acks !== 1) begin
         err_cnt++;
         $display("FAIL req_held_acks got %0d want 1", acks);
      end
      req = 1'b0;
   endtask

   // SETUP=0 PULSE=1 HOLD=0 TURN=0: req held cycles 0-2 gives two transfers
   // (strobe on cycles 1 and 3), the second accepted on the first IDLE cycle.
   task automatic test_back_to_back();
      logic [11:0] exp_v;
      logic        on;
      ena = 1'b1; data_f = 8'h5A; req_f = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         req_f = (c <= 2);
         if (c == 2) data_f = 8'h96;
         on = (c == 1 || c == 3);
         exp_v = {on, on, ~on, ~on, !on ? 8'hFF : ((c == 1) ? 8'h5A : 8'h96)};
         vec_cnt++;
         if ({ack_f, busy_f, oe_n_f, strobe_n_f, dout_f} !== exp_v) begin
            err_cnt++;
            $display("FAIL back_to_back c=%0d got %h want %h", c,
                     {ack_f, busy_f, oe_n_f, strobe_n_f, dout_f}, exp_v);
         end
      end
      req_f = 1'b0;
   endtask

   task automatic test_readback();
      ena = 1'b1; din = 8'h3D; data = 8'h3C; req = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         step();
         req = 1'b0;
         vec_cnt++;
         if (err !== ((c >= 5) ? RB_ERR : 1'b0)) begin
            err_cnt++;
            $display("FAIL readback_bad c=%0d got %b want %b", c, err, (c >= 5) ? RB_ERR : 1'b0);
         end
      end
      din = 8'h3C; req = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         step();
         req = 1'b0;
         vec_cnt++;
         if (err !== 1'b0) begin
            err_cnt++;
            $display("FAIL readback_good c=%0d got %b want 0", c, err);
         end
      end
   endtask

   task automatic test_mid_reset();
      ena = 1'b1; din = 8'h00; data = 8'hE7; req = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         req = 1'b0;
      end
      vec_cnt++;
      if ({strobe_n, oe_n} !== 2'b00) begin
         err_cnt++;
         $display("FAIL mid_reset_pre got strobe_n=%b oe_n=%b want 0 0", strobe_n, oe_n);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vec_cnt++;
      if ({ack, busy, oe_n, strobe_n, err, dout} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF}) begin
         err_cnt++;
         $display("FAIL mid_reset_async got ack=%b busy=%b oe_n=%b strobe_n=%b err=%b dout=%h",
                  ack, busy, oe_n, strobe_n, err, dout);
      end
      step();
      reset_n = 1'b1;
      step(); step();
      vec_cnt++;
      if ({busy, oe_n, strobe_n, dout} !== {1'b0, 1'b1, 1'b1, 8'hFF}) begin
         err_cnt++;
         $display("FAIL mid_reset_after got busy=%b oe_n=%b strobe_n=%b dout=%h",
                  busy, oe_n, strobe_n, dout);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ena_slow();
      test_req_held();
      test_back_to_back();
      test_readback();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/bus_pin_driver.md
# bus_pin_driver

Output-side counterpart to the GPIO input filter: sequences a parallel word onto external bus pins with programmable setup, strobe, hold and turnaround, all timed in `ena` ticks, the same enable used by the input filters. It sits between internal bus logic and the FPGA output buffers. It owns the output-enable so the bus is never driven during turnaround. Optional readback compares the filtered pin state against the driven word to flag bus contention.

## Interface
- `WIDTH`, 8: data pin count.
- `SETUP`, 2: `ena` ticks of data+OE before strobe, range 0..15.
- `PULSE`, 2: `ena` ticks strobe held low, range 1..15.
- `HOLD`, 1: `ena` ticks data+OE held after strobe release, range 0..15.
- `TURN`, 1: `ena` ticks bus released before the next request is accepted, range 0..15.

- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ena` in 1: timing tick; counters and state advance only on cycles with `ena`=1.
- `req` in 1: start a transfer; sampled on every `clk`.
- `data` in WIDTH: word to drive; captured on acceptance.
- `din` in WIDTH: filtered pin readback, fed from the input filters.
- `ack` out 1: one-`clk` pulse on the cycle after acceptance.
- `busy` out 1: transfer in progress.
- `dout` out WIDTH: pin data.
- `oe_n` out 1: active-low output enable for `dout`.
- `strobe_n` out 1: active-low bus strobe.
- `err` out 1: sticky contention flag.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN. A tick counter of 4 bits is loaded on each state entry.
- IDLE:
  - `req`=1 is accepted on any `clk`, independent of `ena`. `data` is latched and `err` is cleared.
  - Next state is SETUP, or STROBE if `SETUP`=0.
  - `req` is ignored in every other state; there is no queue.
- SETUP: `oe_n`=0, `dout`=latched word, `strobe_n`=1. Exits to STROBE after `SETUP` `ena` ticks.
- STROBE: `strobe_n`=0, data and OE held. Exits after `PULSE` ticks to HOLD, or to TURN if `HOLD`=0.
- HOLD: `strobe_n`=1, data and OE held. Exits after `HOLD` ticks to TURN.
- TURN: `oe_n`=1, `dout`=all ones. Exits after `TURN` ticks to IDLE, or directly from the previous state to IDLE if `TURN`=0.
- IDLE outputs: `oe_n`=1, `strobe_n`=1, `dout`=all ones.
- `busy`=1 from the cycle after acceptance through the last TURN cycle. `busy` is 0 on the first IDLE cycle, and a new `req` is accepted on that same cycle.
- Reset at any time, including mid-transfer, forces immediate return to reset values. The bus is released asynchronously.

## Timing
- Reset values: `dout`=all ones, `oe_n`=1, `strobe_n`=1, `busy`=0, `ack`=0, `err`=0; state IDLE.
- Acceptance at clk edge N:
  - `oe_n`, `dout`, `busy` and `ack` change at edge N+1.
  - `ack` drops at edge N+2.
- A tick counts only if `ena`=1 on a cycle while already in the state; the entry cycle does not count.
- State duration = K ticks. With `ena` held at 1, that is exactly K clk cycles.
- With `ena` held at 1, total busy cycles = SETUP+PULSE+HOLD+TURN.
- `ena`=0 freezes the state and counter; outputs hold.
- All outputs are registered and glitch-free.
- `oe_n` deasserts on the same edge as the last HOLD/STROBE cycle ends, never before `strobe_n` returns high.

## Configuration
- `BUS_PIN_DRIVER_READBACK_EN` defined:
  - On the `ena` tick that ends STROBE, `din` is compared with the latched word.
  - Any mismatch sets `err`=1 on the next edge. `err` stays 1 until the next accepted `req` or reset.
- Not defined: `din` is ignored and `err` is tied to 0. Ports remain present.

## Test plan
- Reset, then release with `ena`=1 and defaults:
  - Outputs hold reset values until `req`.
  - `req` with `data`=8'hA5 gives `oe_n`=0 for 5 cycles, `strobe_n`=0 on cycles 3–4 after acceptance, `busy` for 6 cycles, `ack` once.
- `ena` toggling 1-in-4 with defaults: every phase lasts exactly 4× its tick count in clk cycles. `dout` stays 8'hA5 throughout OE.
- `SETUP`=0, `HOLD`=0, `TURN`=0, `PULSE`=1: `strobe_n` low on the first cycle after acceptance. Back-to-back `req` is accepted on the first IDLE cycle.
- `req` held high during the whole transfer: only one `ack` per transfer. `data` changing mid-transfer does not alter `dout`.
- `reset_n` pulsed low during STROBE: `oe_n`=1, `strobe_n`=1 and `busy`=0 immediately, with no clk edge required.
- With READBACK_EN: drive `data`=8'h3C with `din`=8'h3D, so `err`=1 after STROBE. The next `req` clears `err`, and a matching `din` keeps `err`=0.
